// File: rtl/la_pkg.sv
// Shared types for the logic-analyzer acquisition sequencer.
package la_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    ARMED = 2'd2,
    POST  = 2'd3
  } la_acq_st_t;

  localparam int unsigned LA_CW = 32;

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle: d = destination (sink) view, s = source view.
interface axi4_stream_if #(
  parameter int unsigned DN = 1,
  parameter type DT = logic [7:0]
) (
  input logic ACLK,
  input logic ARESETn
);

  DT    [DN-1:0] TDATA;
  logic [DN-1:0] TKEEP;
  logic          TVALID;
  logic          TREADY;
  logic          TLAST;
  logic          transf;

  assign transf = TVALID & TREADY;

  modport d (
    input  ACLK, ARESETn, TDATA, TKEEP, TVALID, TLAST, transf,
    output TREADY
  );

  modport s (
    input  ACLK, ARESETn, TREADY, transf,
    output TDATA, TKEEP, TVALID, TLAST
  );

endinterface

// File: rtl/la_trg_pos.sv
// Lowest-set-lane priority encoder for the masked trigger vector; pos = DN when none set.
module la_trg_pos #(
  parameter int unsigned DN = 1
) (
  input  logic [DN-1:0]      vec,
  output logic               hit,
  output logic [$clog2(DN):0] pos
);

  localparam int unsigned PW = $clog2(DN) + 1;

  always_comb begin
    hit = |vec;
    pos = PW'(DN);
    for (int i = int'(DN) - 1; i >= 0; i--) begin
      if (vec[i]) pos = PW'(i);
    end
  end

endmodule

// File: rtl/la_acq_ctl.sv
// Logic-analyzer acquisition sequencer: pre-trigger fill, trigger qualify, post count, stop/re-arm.
//   state | meaning
//   IDLE  | stream dropped, waiting for ctl_acq
//   PRE   | filling pre-trigger window, triggers ignored
//   ARMED | waiting for hardware or software trigger
//   POST  | counting post-trigger beats up to TLAST
module la_acq_ctl
  import la_pkg::*;
#(
  parameter int unsigned DN = 1,
  parameter type DT = logic [7:0],
  parameter int unsigned CW = LA_CW
) (
  axi4_stream_if.d            sti,
  axi4_stream_if.s            sto,
  input  logic                ctl_rst,
  input  logic                ctl_acq,
  input  logic                ctl_stp,
  input  logic                ctl_trg,
  input  logic                cfg_con,
  input  logic [CW-1:0]       cfg_pre,
  input  logic [CW-1:0]       cfg_pst,
  input  logic [DN-1:0]       trg,
  output logic                sts_acq,
  output logic                sts_arm,
  output logic                sts_trg,
  output logic [CW-1:0]       sts_pre,
  output logic [CW-1:0]       sts_pst,
  output logic [$clog2(DN):0] sts_pos,
  output logic                evt_stp
);

  localparam int unsigned PW = $clog2(DN) + 1;

  la_acq_st_t    state, nxt, ent_st;
  logic          transf, hw_hit, trg_any, last_beat;
  logic          trg_pnd, pnd_nxt;
  logic          clr, evt_set, pre_inc, pst_inc, accept, done;
  logic [PW-1:0] hw_pos;
  logic [CW-1:0] pre_lim, pst_lim;
  DT    [DN-1:0] dat;

  la_trg_pos #(.DN(DN)) u_trg_pos (
    .vec (trg & sti.TKEEP),
    .hit (hw_hit),
    .pos (hw_pos)
  );

  // Zero-latency pass-through; IDLE sinks and discards the stream.
  assign dat         = sti.TDATA;
  assign sto.TDATA   = dat;
  assign sto.TKEEP   = sti.TKEEP;
  assign sto.TVALID  = sti.TVALID & (state != IDLE);
  assign sti.TREADY  = (state == IDLE) ? 1'b1 : sto.TREADY;
  assign sto.TLAST   = last_beat;

  assign transf  = sti.transf;
  assign trg_any = hw_hit | ctl_trg | trg_pnd;
  assign pre_lim = cfg_pre - CW'(1);
  assign pst_lim = cfg_pst - CW'(1);
  assign ent_st  = (cfg_pre == '0) ? ARMED : PRE;
  assign sts_acq = (state != IDLE);
  assign sts_arm = (state == ARMED);

  assign last_beat = ((state == ARMED) && trg_any && (cfg_pst == '0)) ||
                     ((state == POST) && (sts_pst == pst_lim));

  always_comb begin
    nxt     = state;
    clr     = 1'b0;
    evt_set = 1'b0;
    pre_inc = 1'b0;
    pst_inc = 1'b0;
    accept  = 1'b0;
    done    = 1'b0;
    pnd_nxt = trg_pnd;
    if ((state != IDLE) && ctl_stp) begin
      nxt     = IDLE;
      evt_set = 1'b1;
      pnd_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctl_acq && !ctl_stp) begin
            nxt = ent_st;
            clr = 1'b1;
          end
        end
        PRE: begin
          if (transf) begin
            pre_inc = 1'b1;
            if (sts_pre == pre_lim) nxt = ARMED;
          end
        end
        ARMED: begin
          if (transf && trg_any) begin
            accept  = 1'b1;
            pnd_nxt = 1'b0;
            if (cfg_pst == '0) done = 1'b1;
            else               nxt  = POST;
          end else if (ctl_trg) begin
            pnd_nxt = 1'b1;
          end
        end
        POST: begin
          if (transf) begin
            pst_inc = 1'b1;
            if (sts_pst == pst_lim) done = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
    // Continuous mode restarts the next capture on the edge that ends this one.
    if (done) begin
      evt_set = 1'b1;
      nxt     = cfg_con ? ent_st : IDLE;
      clr     = cfg_con;
      pnd_nxt = 1'b0;
    end
  end

  always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
    if (!sti.ARESETn) begin
      state <= IDLE;
    end else if (ctl_rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge sti.ACLK or negedge sti.ARESETn) begin
    if (!sti.ARESETn) begin
      sts_pre <= '0;
      sts_pst <= '0;
      sts_trg <= 1'b0;
      sts_pos <= '0;
      evt_stp <= 1'b0;
      trg_pnd <= 1'b0;
    end else if (ctl_rst) begin
      sts_pre <= '0;
      sts_pst <= '0;
      sts_trg <= 1'b0;
      sts_pos <= '0;
      evt_stp <= 1'b0;
      trg_pnd <= 1'b0;
    end else begin
      evt_stp <= evt_set;
      trg_pnd <= pnd_nxt;
      if (clr) begin
        sts_pre <= '0;
        sts_pst <= '0;
        sts_trg <= 1'b0;
        sts_pos <= '0;
      end else begin
        if (pre_inc) sts_pre <= sts_pre + CW'(1);
        if (pst_inc) sts_pst <= sts_pst + CW'(1);
        if (accept) begin
          sts_trg <= 1'b1;
          sts_pos <= hw_hit ? hw_pos : PW'(DN);
        end
      end
    end
  end

endmodule

// File: tb/tb_la_acq_ctl.sv
// Directed bench for la_acq_ctl (DN=4) with an output-beat scoreboard.
module tb_la_acq_ctl;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic        clk, rst_n;
  logic        ctl_rst, ctl_acq, ctl_stp, ctl_trg, cfg_con;
  logic [31:0] cfg_pre, cfg_pst;
  logic [3:0]  trg;
  logic        sts_acq, sts_arm, sts_trg, evt_stp;
  logic [31:0] sts_pre, sts_pst;
  logic [2:0]  sts_pos;

  int    n_chk = 0;
  int    n_fail = 0;
  int    evt_cnt = 0;
  int    evt_base;
  logic  rnd = 1'b0;
  logic [7:0] beat_id = 8'd0;
  beat_t sb[$];

  axi4_stream_if #(.DN(4), .DT(logic [7:0])) sti_if (.ACLK(clk), .ARESETn(rst_n));
  axi4_stream_if #(.DN(4), .DT(logic [7:0])) sto_if (.ACLK(clk), .ARESETn(rst_n));

  la_acq_ctl #(.DN(4), .DT(logic [7:0]), .CW(32)) dut (
    .sti     (sti_if),
    .sto     (sto_if),
    .ctl_rst (ctl_rst),
    .ctl_acq (ctl_acq),
    .ctl_stp (ctl_stp),
    .ctl_trg (ctl_trg),
    .cfg_con (cfg_con),
    .cfg_pre (cfg_pre),
    .cfg_pst (cfg_pst),
    .trg     (trg),
    .sts_acq (sts_acq),
    .sts_arm (sts_arm),
    .sts_trg (sts_trg),
    .sts_pre (sts_pre),
    .sts_pst (sts_pst),
    .sts_pos (sts_pos),
    .evt_stp (evt_stp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard
  always @(negedge clk) begin
    if (sto_if.TVALID && sto_if.TREADY) begin
      chk("unexpected_beat", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        beat_t e;
        e = sb.pop_front();
        chk("tlast", sto_if.TLAST, e.last);
        chk("tdata", sto_if.TDATA, e.data);
        chk("tkeep", sto_if.TKEEP, e.keep);
      end
    end
    if (evt_stp) evt_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic send(input logic [3:0] t, input logic [3:0] k, input logic exp_last);
    logic xfer;
    xfer = 1'b0;
    beat_id++;
    sti_if.TVALID = 1'b1;
    sti_if.TDATA  = {4{beat_id}};
    sti_if.TKEEP  = k;
    trg           = t;
    sb.push_back('{data: {4{beat_id}}, keep: k, last: exp_last});
    for (int n = 0; n < 64 && !xfer; n++) begin
      sto_if.TREADY = (rnd && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      xfer = sti_if.TVALID && sti_if.TREADY;
      @(posedge clk); #1;
    end
    chk("send_done", xfer, 1);
    sti_if.TVALID = 1'b0;
    trg           = 4'h0;
    sto_if.TREADY = 1'b1;
  endtask

  task automatic pulse_acq;
    ctl_acq = 1'b1; @(posedge clk); #1; ctl_acq = 1'b0;
  endtask

  task automatic pulse_stp;
    ctl_stp = 1'b1; @(posedge clk); #1; ctl_stp = 1'b0;
  endtask

  task automatic pulse_trg;
    ctl_trg = 1'b1; @(posedge clk); #1; ctl_trg = 1'b0;
  endtask

  task automatic chk_end(input string tag, input logic acq_after);
    chk({tag, "_evt"}, evt_stp, 1);
    chk({tag, "_acq"}, sts_acq, acq_after);
    @(posedge clk); #1;
    chk({tag, "_evt_drop"}, evt_stp, 0);
  endtask

  initial begin
    rst_n = 1'b0; ctl_rst = 1'b0; ctl_acq = 1'b0; ctl_stp = 1'b0; ctl_trg = 1'b0;
    cfg_con = 1'b0; cfg_pre = 32'd0; cfg_pst = 32'd0; trg = 4'h0;
    sti_if.TVALID = 1'b1; sti_if.TDATA = '0; sti_if.TKEEP = 4'hF; sti_if.TLAST = 1'b0;
    sto_if.TREADY = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_acq", sts_acq, 0);
    chk("rst_arm", sts_arm, 0);
    chk("rst_trg", sts_trg, 0);
    chk("rst_pre", sts_pre, 0);
    chk("rst_pst", sts_pst, 0);
    chk("rst_pos", sts_pos, 0);
    chk("rst_evt", evt_stp, 0);
    chk("idle_tvalid", sto_if.TVALID, 0);
    chk("idle_tready", sti_if.TREADY, 1);
    sti_if.TVALID = 1'b0; sto_if.TREADY = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Pre window of 4: trigger on beat 2 ignored, accepted on beat 6
    cfg_pre = 32'd4; cfg_pst = 32'd2;
    pulse_acq();
    chk("a_acq", sts_acq, 1);
    chk("a_arm_pre", sts_arm, 0);
    send(4'h0, 4'hF, 1'b0);
    send(4'h1, 4'hF, 1'b0);
    send(4'h0, 4'hF, 1'b0);
    send(4'h0, 4'hF, 1'b0);
    chk("a_armed", sts_arm, 1);
    chk("a_pre_sat", sts_pre, 4);
    chk("a_pre_trg_ignored", sts_trg, 0);
    send(4'h0, 4'hF, 1'b0);
    chk("a_no_trg", sts_trg, 0);
    send(4'h1, 4'hF, 1'b0);
    chk("a_trg", sts_trg, 1);
    chk("a_pos", sts_pos, 0);
    send(4'h0, 4'hF, 1'b0);
    send(4'h0, 4'hF, 1'b1);
    chk_end("a", 1'b0);
    chk("a_trg_held", sts_trg, 1);
    chk("a_pst", sts_pst, 2);

    // Async reset in the middle of the post window
    cfg_pre = 32'd4; cfg_pst = 32'd8;
    pulse_acq();
    repeat (4) send(4'h0, 4'hF, 1'b0);
    send(4'h2, 4'hF, 1'b0);
    chk("b_pos", sts_pos, 1);
    repeat (3) send(4'h0, 4'hF, 1'b0);
    chk("b_pst", sts_pst, 3);
    sti_if.TVALID = 1'b1; sto_if.TREADY = 1'b0;
    #1 chk("b_tvalid_on", sto_if.TVALID, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("b_acq", sts_acq, 0);
    chk("b_pst_rst", sts_pst, 0);
    chk("b_pre_rst", sts_pre, 0);
    chk("b_trg_rst", sts_trg, 0);
    chk("b_pos_rst", sts_pos, 0);
    chk("b_tvalid_off", sto_if.TVALID, 0);
    sti_if.TVALID = 1'b0; sto_if.TREADY = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero pre and post: the trigger beat is the last beat
    cfg_pre = 32'd0; cfg_pst = 32'd0;
    pulse_acq();
    chk("c_armed", sts_arm, 1);
    send(4'h1, 4'hF, 1'b1);
    chk_end("c", 1'b0);

    // Trigger lanes masked by TKEEP
    cfg_pst = 32'd1;
    pulse_acq();
    send(4'hC, 4'h3, 1'b0);
    chk("d_masked", sts_trg, 0);
    chk("d_still_armed", sts_arm, 1);
    send(4'hC, 4'h7, 1'b0);
    chk("d_trg", sts_trg, 1);
    chk("d_pos", sts_pos, 2);
    send(4'h0, 4'hF, 1'b1);
    chk_end("d", 1'b0);

    // Software trigger held pending until the next beat
    pulse_acq();
    pulse_trg();
    chk("g_pending", sts_trg, 0);
    send(4'h0, 4'hF, 1'b0);
    chk("g_trg", sts_trg, 1);
    chk("g_pos_sw", sts_pos, 4);
    send(4'h0, 4'hF, 1'b1);
    chk_end("g", 1'b0);

    // Random backpressure over a 5-beat post window
    cfg_pst = 32'd5;
    pulse_acq();
    send(4'h1, 4'hF, 1'b0);
    rnd = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      send(4'h0, 4'hF, i == 5);
      if (i < 5) chk("e_pst", sts_pst, 32'(i));
    end
    rnd = 1'b0;
    chk("e_pst_final", sts_pst, 5);
    chk_end("e", 1'b0);

    // Continuous mode: three captures, then abort while armed
    cfg_pre = 32'd2; cfg_pst = 32'd1; cfg_con = 1'b1;
    evt_base = evt_cnt;
    pulse_acq();
    for (int c = 0; c < 3; c++) begin
      send(4'h0, 4'hF, 1'b0);
      send(4'h0, 4'hF, 1'b0);
      send(4'h8, 4'hF, 1'b0);
      send(4'h0, 4'hF, 1'b1);
      chk("f_evt", evt_stp, 1);
      chk("f_rearm_acq", sts_acq, 1);
      chk("f_rearm_pre", sts_arm, 0);
      chk("f_pre_clr", sts_pre, 0);
    end
    send(4'h0, 4'hF, 1'b0);
    send(4'h0, 4'hF, 1'b0);
    chk("f_armed", sts_arm, 1);
    pulse_stp();
    cfg_con = 1'b0;
    chk_end("f_stp", 1'b0);
    chk("f_pre_hold", sts_pre, 2);
    chk("f_evt_count", 64'(evt_cnt - evt_base), 4);

    repeat (3) @(posedge clk);
    #1 chk("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
